reg_file_sb: RTL and testbench

Parametrised 2-read/1-write CPU register file with a per-register busy scoreboard, write-to-read bypass and an immediate operand path on read port 2. After reset it sequences its own initialisation, one register per cycle, and raises ready when done. It sits between decode (read/issue) and write-back (write) in the CPU datapath.

---
 rtl/reg_file_sb.sv | 143 ++++++++++++++
 tb/tb_reg_file_sb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with busy scoreboard, bypass and immediate.
// Self-initialises one register per cycle after reset, then raises ready.
module reg_file_sb #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int IMM_W      = 4,
  parameter int IMM_SIGNED = 0,
  parameter int INIT_MODE  = 1,
  parameter int ZERO_R0    = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  input  logic              imm_sel,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd1_busy,
  output logic              rd2_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam bit ZR       = (ZERO_R0 != 0);
  localparam bit SGN      = (IMM_SIGNED != 0);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] imm_ext;
  logic              run, wr_ok;
  logic              hit1, hit2, z1, z2;

  assign run   = (state_q == S_RUN);
  assign wr_ok = run & wr_en & ~(ZR & (wr_addr == '0));
  assign hit1  = run & wr_en & (wr_addr == rd1_addr);
  assign hit2  = run & wr_en & (wr_addr == rd2_addr);
  assign z1    = ZR & (rd1_addr == '0);
  assign z2    = ZR & (rd2_addr == '0);

  generate
    if (IMM_W < DATA_W) begin : g_ext
      logic sbit;
      assign sbit    = SGN & imm[IMM_W-1];
      assign imm_ext = {{(DATA_W-IMM_W){sbit}}, imm};
    end else begin : g_noext
      assign imm_ext = imm;
    end
  endgenerate

  // A write being retired this cycle resolves the hazard via the bypass.
  assign rd1_busy = busy_q[rd1_addr] & ~hit1;
  assign rd2_busy = busy_q[rd2_addr] & ~hit2 & ~imm_sel;

  assign ready    = run;
  assign rd1_data = rd1_q;
  assign rd2_data = rd2_q;

  // Init sequencer and array write-port select.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    unique case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_RUN;
      end
      S_RUN: begin
        mem_we = wr_ok;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Registered read ports with bypass and immediate select.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (run) begin
      if (z1)        rd1_d = '0;
      else if (hit1) rd1_d = wr_data;
      else           rd1_d = regs_q[rd1_addr];
      if (imm_sel)   rd2_d = imm_ext;
      else if (z2)   rd2_d = '0;
      else if (hit2) rd2_d = wr_data;
      else           rd2_d = regs_q[rd2_addr];
    end
  end

  // Scoreboard update: issue set overrides write-back clear.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (wr_en)  busy_d[wr_addr]  = 1'b0;
      if (iss_en) busy_d[iss_addr] = 1'b1;
    end
    if (ZR) busy_d[0] = 1'b0;
  end

  // Control, scoreboard and read-data state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  // Register array; contents come from the init sequence, not reset.
  always_ff @(posedge clk) begin
    if (mem_we) regs_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: two configurations driven in lockstep.
// Expected outputs come from a behavioural model of the register file.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rd1_addr = '0, rd2_addr = '0;
  logic        imm_sel = 1'b0;
  logic [3:0]  imm = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [3:0]  iss_addr = '0;

  logic        ready_o [2];
  logic [15:0] rd1_o [2];
  logic [15:0] rd2_o [2];
  logic        b1_o [2];
  logic        b2_o [2];

  always #5 clk = ~clk;

  reg_file_sb u0 (
    .clk(clk), .reset(reset), .ready(ready_o[0]),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .imm_sel(imm_sel), .imm(imm),
    .rd1_data(rd1_o[0]), .rd2_data(rd2_o[0]),
    .rd1_busy(b1_o[0]), .rd2_busy(b2_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  reg_file_sb #(
    .INIT_MODE(0), .IMM_SIGNED(1), .ZERO_R0(1)
  ) u1 (
    .clk(clk), .reset(reset), .ready(ready_o[1]),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .imm_sel(imm_sel), .imm(imm),
    .rd1_data(rd1_o[1]), .rd2_data(rd2_o[1]),
    .rd1_busy(b1_o[1]), .rd2_busy(b2_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  bit cfg_init [2] = '{1'b1, 1'b0};
  bit cfg_sgn  [2] = '{1'b0, 1'b1};
  bit cfg_zr   [2] = '{1'b0, 1'b1};

  int          cyc_m [2];
  logic [15:0] reg_m [2][16];
  bit          busy_m [2][16];

  typedef struct {
    int          inst;
    logic        rdy;
    logic [15:0] d1;
    logic [15:0] d2;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, int i, logic [15:0] act,
                     logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h",
               nm, i, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] rd_m(int i, logic [3:0] a);
    if (cfg_zr[i] && a == 0) return 16'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return reg_m[i][a];
  endfunction

  // Inputs are set at negedge; check busy, then model the next edge.
  task automatic tick();
    exp_t e;
    bit run, eb1, eb2;
    logic [15:0] ext;
    #1;
    for (int i = 0; i < 2; i++) begin
      run = !reset && cyc_m[i] >= 16;
      eb1 = run && busy_m[i][rd1_addr]
            && !(wr_en && wr_addr == rd1_addr);
      eb2 = run && !imm_sel && busy_m[i][rd2_addr]
            && !(wr_en && wr_addr == rd2_addr);
      chk("rd1_busy", i, 16'(b1_o[i]), 16'(eb1));
      chk("rd2_busy", i, 16'(b2_o[i]), 16'(eb2));
      e.inst = i;
      if (reset) begin
        chk("rst_ready", i, 16'(ready_o[i]), 16'h0);
        chk("rst_rd1", i, rd1_o[i], 16'h0);
        cyc_m[i] = 0;
        for (int k = 0; k < 16; k++) busy_m[i][k] = 1'b0;
        e.rdy = 1'b0; e.d1 = '0; e.d2 = '0;
      end else if (!run) begin
        cyc_m[i]++;
        e.rdy = (cyc_m[i] == 16);
        e.d1 = '0; e.d2 = '0;
        if (cyc_m[i] == 16)
          for (int k = 0; k < 16; k++)
            reg_m[i][k] = cfg_init[i] ? 16'(k) : 16'h0;
      end else begin
        ext = (cfg_sgn[i] && imm[3]) ? {12'hFFF, imm}
                                     : {12'h000, imm};
        e.rdy = 1'b1;
        e.d1 = rd_m(i, rd1_addr);
        e.d2 = imm_sel ? ext : rd_m(i, rd2_addr);
        if (wr_en && !(cfg_zr[i] && wr_addr == 0))
          reg_m[i][wr_addr] = wr_data;
        if (wr_en) busy_m[i][wr_addr] = 1'b0;
        if (iss_en && !(cfg_zr[i] && iss_addr == 0))
          busy_m[i][iss_addr] = 1'b1;
      end
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; imm_sel = 0;
  endtask

  task automatic do_reset(int n);
    idle();
    reset = 1;
    repeat (n) tick();
    reset = 0;
  endtask

  // Monitor: compare registered outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("ready", e.inst, 16'(ready_o[e.inst]), 16'(e.rdy));
        chk("rd1_data", e.inst, rd1_o[e.inst], e.d1);
        chk("rd2_data", e.inst, rd2_o[e.inst], e.d2);
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset(2);
    for (int c = 0; c < 16; c++) begin
      idle();
      if (c == 3) begin
        wr_en = 1; wr_addr = 12; wr_data = 16'hFFFF;
        iss_en = 1; iss_addr = 9;
      end
      tick();
    end
    idle(); rd1_addr = 5; rd2_addr = 12; tick();
    wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
    rd1_addr = 3; tick();
    idle(); tick();
    iss_en = 1; iss_addr = 7; tick();
    idle(); rd2_addr = 7; tick();
    wr_en = 1; wr_addr = 7; wr_data = 16'h1234; tick();
    idle(); tick();
    iss_en = 1; iss_addr = 7;
    wr_en = 1; wr_addr = 7; wr_data = 16'h4321; tick();
    idle(); tick();
    imm_sel = 1; imm = 4'hA; tick();
    idle(); iss_en = 1; iss_addr = 2; tick();
    idle(); rd1_addr = 2; tick();
    do_reset(2);
    rd1_addr = 2; rd2_addr = 7;
    repeat (16) tick();
    tick();
    wr_en = 1; wr_addr = 0; wr_data = 16'h55AA; tick();
    idle(); rd1_addr = 0; rd2_addr = 0; tick();
    iss_en = 1; iss_addr = 0; tick();
    idle(); tick();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        rd1_addr = 4'($urandom_range(0, 15));
        rd2_addr = 4'($urandom_range(0, 15));
        wr_addr  = 4'($urandom_range(0, 15));
        iss_addr = 4'($urandom_range(0, 15));
        wr_data  = 16'($urandom);
        imm      = 4'($urandom);
        wr_en    = ($urandom_range(0, 1) == 1);
        iss_en   = ($urandom_range(0, 2) == 0);
        imm_sel  = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    idle();
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
